// File: rtl/mem_responder.sv
// mem_responder: memory-side responder closing the controller's memrd/memwr
// handshake. Latches address/data/op on a request in IDLE, waits WAIT_CYCLES,
// performs the access on an internal word array and pulses mfc for one cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   memrd, memwr      - read / write strobes from the controller
//   addr, wdata       - word address (MAR) and write data (MDR)
//   rdata             - registered read data, holds last completed read
//   mfc               - one-cycle completion pulse
//   busy              - request in progress or waiting for strobe release
//   err               - one-cycle pulse when both strobes are high in IDLE
module mem_responder #(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memrd,
  input  logic          memwr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          mfc,
  output logic          busy,
  output logic          err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Counter must be able to hold WAIT_CYCLES itself; keep at least one bit.
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          op_wr_q;

  logic [DW-1:0] mem [2**AW];

  logic          req;
  logic          acc_en;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  assign req  = memrd ^ memwr;
  assign busy = (state != S_IDLE);
  assign mfc  = (state == S_DONE);

  // Access happens on the edge that enters DONE. With zero wait states that
  // edge is the request edge itself, so the live operands are used; otherwise
  // the latched ones are. Reset suppresses the access so an abandoned write
  // never reaches the array.
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = op_wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (!rst) begin
      if (state == S_IDLE && req && WAIT_CYCLES == 0) begin
        acc_en    = 1'b1;
        acc_wr    = memwr;
        acc_addr  = addr;
        acc_wdata = wdata;
      end else if (state == S_WAIT && cnt == '0) begin
        acc_en = 1'b1;
      end
    end
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_wr) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (acc_en && !acc_wr) begin
        rdata <= mem[acc_addr];
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_wr_q <= memwr;
            cnt     <= CW'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end else if (memrd && memwr) begin
            err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // A strobe still held here must be dropped before the next request,
          // otherwise it would immediately re-trigger the same access.
          state <= (memrd || memwr) ? S_RELEASE : S_IDLE;
        end
        S_RELEASE: begin
          if (!memrd && !memwr) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
// (DW=16, AW=8, WAIT_CYCLES=2). Inputs change 1 time unit after a rising
// edge; outputs are checked at the same point, after the edge has settled.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        memrd;
  logic        memwr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        mfc;
  logic        busy;
  logic        err;

  int n_cmp;
  int n_bad;

  mem_responder #(.DW(16), .AW(8), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .memrd (memrd),
    .memwr (memwr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .mfc   (mfc),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access with WAIT_CYCLES=2: strobe held through WAIT, dropped in DONE.
  // addr/wdata are switched to a2/d2 during WAIT to exercise latching.
  task automatic access(input string tag, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [7:0] a2, input logic [15:0] d2);
    memrd = ~wr;
    memwr = wr;
    addr  = a;
    wdata = d;
    tick();                                   // E0
    chk({tag, "_busy_e0"}, 16'(busy), 16'd1);
    chk({tag, "_mfc_e0"}, 16'(mfc), 16'd0);
    addr  = a2;
    wdata = d2;
    tick();                                   // E1
    chk({tag, "_mfc_e1"}, 16'(mfc), 16'd0);
    tick();                                   // E2
    chk({tag, "_mfc_e2"}, 16'(mfc), 16'd0);
    tick();                                   // E3: DONE
    chk({tag, "_mfc_e3"}, 16'(mfc), 16'd1);
    memrd = 1'b0;
    memwr = 1'b0;
    tick();
    chk({tag, "_idle"}, 16'(busy), 16'd0);
    chk({tag, "_mfc_off"}, 16'(mfc), 16'd0);
  endtask

  initial begin
    int pulses;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    memrd = 1'b1;
    memwr = 1'b0;
    addr  = 8'h00;
    wdata = 16'h0000;

    // Reset with memrd held high.
    tick();
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mfc", 16'(mfc), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    tick();
    chk("rst2_mfc", 16'(mfc), 16'd0);
    chk("rst2_busy", 16'(busy), 16'd0);
    rst   = 1'b0;
    memrd = 1'b0;
    tick();
    chk("post_rst_busy", 16'(busy), 16'd0);

    // Write then read back.
    access("wr05", 1'b1, 8'h05, 16'hBEEF, 8'h05, 16'hBEEF);
    chk("wr05_rdata", rdata, 16'h0000);
    access("rd05", 1'b0, 8'h05, 16'h0000, 8'h05, 16'h0000);
    chk("rd05_rdata", rdata, 16'hBEEF);

    // Latched operands: 0x20 preloaded, then a write to 0x10 whose inputs
    // are changed to 0x20/FFFF during WAIT must not touch 0x20.
    access("wr20", 1'b1, 8'h20, 16'h2020, 8'h20, 16'h2020);
    access("wr10", 1'b1, 8'h10, 16'h1234, 8'h20, 16'hFFFF);
    access("rd10", 1'b0, 8'h10, 16'h0000, 8'h10, 16'h0000);
    chk("rd10_rdata", rdata, 16'h1234);
    access("rd20", 1'b0, 8'h20, 16'h0000, 8'h20, 16'h0000);
    chk("rd20_rdata", rdata, 16'h2020);

    // Held strobe: memrd high for 10 cycles gives one mfc, then RELEASE.
    memrd  = 1'b1;
    addr   = 8'h05;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mfc === 1'b1) pulses++;
      if (i == 4) chk("held_mfc_e3", 16'(mfc), 16'd1);
    end
    chk("held_pulses", 16'(pulses), 16'd1);
    chk("held_busy", 16'(busy), 16'd1);
    chk("held_rdata", rdata, 16'hBEEF);
    memrd = 1'b0;
    tick();
    chk("held_release_idle", 16'(busy), 16'd0);
    chk("held_release_mfc", 16'(mfc), 16'd0);

    // Conflict: both strobes for 2 cycles in IDLE.
    memrd = 1'b1;
    memwr = 1'b1;
    addr  = 8'h05;
    wdata = 16'h0000;
    tick();
    chk("conf1_err", 16'(err), 16'd1);
    chk("conf1_busy", 16'(busy), 16'd0);
    chk("conf1_mfc", 16'(mfc), 16'd0);
    tick();
    chk("conf2_err", 16'(err), 16'd1);
    chk("conf2_busy", 16'(busy), 16'd0);
    memrd = 1'b0;
    memwr = 1'b0;
    tick();
    chk("conf_err_off", 16'(err), 16'd0);
    access("conf_rd05", 1'b0, 8'h05, 16'h0000, 8'h05, 16'h0000);
    chk("conf_rd05_rdata", rdata, 16'hBEEF);

    // Reset in the middle of a write leaves the array untouched.
    access("wr07", 1'b1, 8'h07, 16'h5555, 8'h07, 16'h5555);
    memwr = 1'b1;
    addr  = 8'h07;
    wdata = 16'hAAAA;
    tick();                                   // E0 -> WAIT
    chk("midrst_busy", 16'(busy), 16'd1);
    tick();                                   // still WAIT
    rst   = 1'b1;
    memwr = 1'b0;
    tick();
    chk("midrst_busy0", 16'(busy), 16'd0);
    chk("midrst_mfc0", 16'(mfc), 16'd0);
    chk("midrst_rdata0", rdata, 16'h0000);
    chk("midrst_err0", 16'(err), 16'd0);
    rst = 1'b0;
    tick();
    access("rd07", 1'b0, 8'h07, 16'h0000, 8'h07, 16'h0000);
    chk("rd07_rdata", rdata, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
